e_mdu: RTL
==========

Name: e_mdu

Overview:
- Execute-stage multiply/divide unit. It consumes the rs/rt operands and the decoded MDU operation that the D/E pipeline register delivers to E.
- It holds the architectural HI/LO registers and models the multi-cycle latency of MULT/MULTU/DIV/DIVU through a busy countdown.
- The hazard unit stalls D/E on a dependent MDU instruction using busy.
- MFHI/MFLO results are muxed into the E-stage result path.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >=1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >=1)

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- md_start  input  1  one-cycle strobe: E-stage instruction is an MDU write-type op
- md_op  input  3  1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO; others no-op; sampled only when md_start=1
- md_a  input  32  E-stage rs operand (forwarded)
- md_b  input  32  E-stage rt operand (forwarded)
- md_rdsel  input  1  0=read LO (MFLO), 1=read HI (MFHI)
- busy  output  1  multi-cycle operation in flight
- md_out  output  32  combinational: HI if md_rdsel else LO (committed values)
- hi  output  32  committed HI register
- lo  output  32  committed LO register

Behaviour:
- Reset (reset=0, async):
  - hi=0, lo=0, busy=0, countdown=0, pending result registers=0.
  - Any in-flight operation is aborted and its result is never committed.
- Accept condition: md_start=1 and busy=0 at a rising edge.
  - md_start while busy=1 is ignored completely (no HI/LO change, countdown unaffected). This covers all op codes, including MTHI/MTLO.
- MTHI/MTLO accepted:
  - hi (resp. lo) <= md_a at that edge.
  - busy stays 0; the other register is unchanged.
- MULT/MULTU/DIV/DIVU accepted at edge T0:
  - The result is computed from md_a/md_b sampled at T0 and held in pending registers.
  - Countdown is loaded with N (MULT_CYCLES or DIV_CYCLES).
  - busy=1 for the N cycles following T0.
  - At edge T0+N: hi/lo <= pending, busy <= 0 (same edge).
  - Later operand changes have no effect.
- Arithmetic:
  - MULT: {hi,lo} = signed 64-bit product.
  - MULTU: {hi,lo} = unsigned 64-bit product.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIV special case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero (DIV or DIVU): the full latency is still observed (busy for DIV_CYCLES), then hi/lo are left unchanged.
- md_out/hi/lo reflect committed state only. While busy, they show pre-operation values.
- Countdown width: clog2(max(MULT_CYCLES,DIV_CYCLES)+1) bits. It decrements by 1 per cycle while nonzero; busy = (countdown != 0).
- Back-to-back: an op accepted in the cycle right after busy falls is legal and sees the just-committed hi/lo.
- No flush input: an accepted op always completes unless reset is asserted.

Test Plan:
- MULT md_a=0xFFFFFFFD (-3), md_b=5 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1; md_out with rdsel=0 = 0xFFFFFFF1.
- MULTU md_a=0xFFFFFFFF, md_b=2 -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE; hi/lo hold their old values during all busy cycles.
- DIV md_a=0xFFFFFFF9 (-7), md_b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU md_a=100, md_b=0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO -> busy 10 cycles, hi=0x11, lo=0x22 unchanged.
- MULT started; at busy cycle 2 pulse md_start with MTHI md_a=0xDEAD -> ignored; at completion hi/lo equal the MULT result and busy falls on schedule.
- DIV started; drive reset=0 mid-operation at busy cycle 4 (asynchronous, between edges) -> busy, hi and lo go to 0 immediately; after release, no late commit occurs and busy stays 0.

Source files
------------

// File: rtl/e_mdu.sv
// ============================================================================
// e_mdu : execute-stage multiply/divide unit holding HI/LO with busy countdown
// Revision: 1.0
// ============================================================================
`default_nettype none

module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  input  logic        md_rdsel,
  output logic        busy,
  output logic [31:0] md_out,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [CW-1:0] countdown;
  logic [31:0]   pend_hi;
  logic [31:0]   pend_lo;
  logic          pend_en;

  logic [63:0]        mul_s;
  logic [63:0]        mul_u;
  logic signed [31:0] a_s;
  logic signed [31:0] b_s;
  logic [31:0]        b_nz;
  logic [31:0]        q_s;
  logic [31:0]        r_s;
  logic [31:0]        q_u;
  logic [31:0]        r_u;
  logic               accept;

  assign busy   = (countdown != '0);
  assign accept = md_start && !busy;
  assign md_out = md_rdsel ? hi : lo;

  always_comb begin
    mul_s = {{32{md_a[31]}}, md_a} * {{32{md_b[31]}}, md_b};
    mul_u = {32'd0, md_a} * {32'd0, md_b};
    // A zero divisor is replaced by 1 only to keep the datapath defined; the result is discarded.
    b_nz  = (md_b == 32'd0) ? 32'd1 : md_b;
    a_s   = $signed(md_a);
    b_s   = $signed(b_nz);
    q_u   = md_a / b_nz;
    r_u   = md_a % b_nz;
    if (md_a == 32'h8000_0000 && md_b == 32'hFFFF_FFFF) begin
      q_s = 32'h8000_0000;
      r_s = 32'd0;
    end else begin
      q_s = $unsigned(a_s / b_s);
      r_s = $unsigned(a_s % b_s);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi        <= '0;
      lo        <= '0;
      countdown <= '0;
      pend_hi   <= '0;
      pend_lo   <= '0;
      pend_en   <= 1'b0;
    end else if (accept) begin
      case (md_op)
        OP_MTHI: hi <= md_a;
        OP_MTLO: lo <= md_a;
        OP_MULT: begin
          countdown <= CW'(MULT_CYCLES);
          {pend_hi, pend_lo} <= mul_s;
          pend_en   <= 1'b1;
        end
        OP_MULTU: begin
          countdown <= CW'(MULT_CYCLES);
          {pend_hi, pend_lo} <= mul_u;
          pend_en   <= 1'b1;
        end
        OP_DIV: begin
          countdown <= CW'(DIV_CYCLES);
          pend_hi   <= r_s;
          pend_lo   <= q_s;
          pend_en   <= (md_b != 32'd0);
        end
        OP_DIVU: begin
          countdown <= CW'(DIV_CYCLES);
          pend_hi   <= r_u;
          pend_lo   <= q_u;
          pend_en   <= (md_b != 32'd0);
        end
        default: ;
      endcase
    end else if (busy) begin
      countdown <= countdown - CW'(1);
      if (countdown == CW'(1) && pend_en) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end
  end

endmodule

`default_nettype wire
